// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - RV32I load/store funct3 encodings (loads and stores share 000/001/010)
//   - LSU FSM state encoding
package mem_stage_lsu_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_store_align.sv
// Combinational store lane steering and alignment check.
// Ports:
//   is_store_i  1 = store, 0 = load
//   funct3_i    RV32I load/store funct3
//   offset_i    byte offset addr[1:0]
//   wdata_i     store source data (rs2)
//   we_o        byte write enables (0000 for loads)
//   wdata_o     lane-replicated store data
//   misalign_o  op cannot be issued (misaligned or unused funct3)
module mem_stage_lsu_store_align
  import mem_stage_lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    we_o       = 4'b0000;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    // Byte/half/word encodings are shared by loads and stores, so the
    // store names cover both; LBU/LHU only exist as loads.
    case (funct3_i)
      FNC_SB: begin
        wdata_o = {4{wdata_i[7:0]}};
        we_o    = 4'b0001 << offset_i;
      end
      FNC_SH: begin
        misalign_o = offset_i[0];
        wdata_o    = {2{wdata_i[15:0]}};
        we_o       = offset_i[1] ? 4'b1100 : 4'b0011;
      end
      FNC_SW: begin
        misalign_o = |offset_i;
        we_o       = 4'b1111;
      end
      // A store carrying an unsigned-load funct3 is not a legal encoding,
      // so it is rejected the same way as the unused funct3 values.
      FNC_LBU: misalign_o = is_store_i;
      FNC_LHU: misalign_o = is_store_i | offset_i[0];
      default: misalign_o = 1'b1;
    endcase
    if (!is_store_i) begin
      we_o = 4'b0000;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one op from EX, runs a req/gnt/rvalid
// handshake to data memory and retires into the WB pipeline register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ex_valid/ex_ready               op handshake from EX (ready only in IDLE)
//   ex_is_store/funct3/addr/wdata   op description
//   d_req/d_gnt/d_we/d_addr/d_wdata request channel to data memory
//   d_rvalid/d_rdata                load response channel
//   wb_valid                        one-cycle retire pulse
//   wb_is_load/funct3/offset/rdata  retired op info, raw unextended word
//   misalign                        one-cycle pulse: op rejected at accept
//   bus_err                         one-cycle pulse: access timed out
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        d_req,
  input  logic        d_gnt,
  output logic [3:0]  d_we,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  input  logic        d_rvalid,
  input  logic [31:0] d_rdata,
  output logic        wb_valid,
  output logic        wb_is_load,
  output logic [2:0]  wb_funct3,
  output logic [1:0]  wb_offset,
  output logic [31:0] wb_rdata,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [3:0]  d_we_q, d_we_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_is_load_q, wb_is_load_d;
  logic [2:0]  wb_funct3_q, wb_funct3_d;
  logic [1:0]  wb_offset_q, wb_offset_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        retire;
  logic        timeout_hit;

  logic [3:0]  sa_we;
  logic [31:0] sa_wdata;
  logic        sa_misalign;

  mem_stage_lsu_store_align u_store_align (
    .is_store_i (ex_is_store),
    .funct3_i   (ex_funct3),
    .offset_i   (ex_addr[1:0]),
    .wdata_i    (ex_wdata),
    .we_o       (sa_we),
    .wdata_o    (sa_wdata),
    .misalign_o (sa_misalign)
  );

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    d_we_d       = d_we_q;
    d_addr_d     = d_addr_q;
    d_wdata_d    = d_wdata_q;
    wb_is_load_d = wb_is_load_q;
    wb_rdata_d   = wb_rdata_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    retire       = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        cnt_d = '0;
        if (ex_valid) begin
          if (sa_misalign) begin
            misalign_d = 1'b1;
          end else begin
            state_d    = LSU_REQ;
            is_store_d = ex_is_store;
            funct3_d   = ex_funct3;
            offset_d   = ex_addr[1:0];
            d_we_d     = sa_we;
            d_addr_d   = {ex_addr[31:2], 2'b00};
            d_wdata_d  = sa_wdata;
          end
        end
      end
      LSU_REQ: begin
        // d_rvalid only counts here when it comes with the grant.
        if (d_gnt) begin
          cnt_d = '0;
          if (is_store_q) begin
            retire       = 1'b1;
            wb_is_load_d = 1'b0;
            state_d      = LSU_IDLE;
          end else if (d_rvalid) begin
            retire       = 1'b1;
            wb_is_load_d = 1'b1;
            wb_rdata_d   = d_rdata;
            state_d      = LSU_IDLE;
          end else begin
            state_d = LSU_WAIT;
          end
        end else if (timeout_hit) begin
          cnt_d     = '0;
          bus_err_d = 1'b1;
          state_d   = LSU_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LSU_WAIT: begin
        if (d_rvalid) begin
          cnt_d        = '0;
          retire       = 1'b1;
          wb_is_load_d = 1'b1;
          wb_rdata_d   = d_rdata;
          state_d      = LSU_IDLE;
        end else if (timeout_hit) begin
          cnt_d     = '0;
          bus_err_d = 1'b1;
          state_d   = LSU_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = LSU_IDLE;
      end
    endcase

    wb_valid_d  = retire;
    wb_funct3_d = retire ? funct3_q : wb_funct3_q;
    wb_offset_d = retire ? offset_q : wb_offset_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      offset_q     <= '0;
      d_we_q       <= '0;
      d_addr_q     <= '0;
      d_wdata_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_is_load_q <= 1'b0;
      wb_funct3_q  <= '0;
      wb_offset_q  <= '0;
      wb_rdata_q   <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      d_we_q       <= d_we_d;
      d_addr_q     <= d_addr_d;
      d_wdata_q    <= d_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_is_load_q <= wb_is_load_d;
      wb_funct3_q  <= wb_funct3_d;
      wb_offset_q  <= wb_offset_d;
      wb_rdata_q   <= wb_rdata_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign ex_ready   = (state_q == LSU_IDLE);
  assign d_req      = (state_q == LSU_REQ);
  assign d_we       = d_we_q;
  assign d_addr     = d_addr_q;
  assign d_wdata    = d_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_is_load = wb_is_load_q;
  assign wb_funct3  = wb_funct3_q;
  assign wb_offset  = wb_offset_q;
  assign wb_rdata   = wb_rdata_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a scripted memory responder drives
// each op; expected retire/misalign/bus_err events (with their cycle) are
// queued at accept and compared by a negedge monitor.
module tb_mem_stage_lsu;

  localparam int TO = 4;
  localparam logic [2:0] K_WB   = 3'b001;
  localparam logic [2:0] K_MIS  = 3'b010;
  localparam logic [2:0] K_BERR = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid, ex_ready, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        d_req, d_gnt, d_rvalid;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        wb_valid, wb_is_load, misalign, bus_err;
  logic [2:0]  wb_funct3;
  logic [1:0]  wb_offset;
  logic [31:0] wb_rdata;

  typedef struct {
    logic [2:0]  kind;
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] wb_rdata_m = 32'h0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .d_req(d_req), .d_gnt(d_gnt), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .wb_valid(wb_valid), .wb_is_load(wb_is_load), .wb_funct3(wb_funct3),
    .wb_offset(wb_offset), .wb_rdata(wb_rdata),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference alignment/steering, written from the RV32I byte-lane rules.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [1:0] off,
                                input logic [31:0] wd, output logic mis,
                                output logic [3:0] we, output logic [31:0] wo);
    mis = 1'b0;
    we  = 4'b0000;
    wo  = wd;
    if (st) begin
      if (f3 == 3'd0) begin
        we = (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 : (off == 2'd2) ? 4'b0100 : 4'b1000;
        wo = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      end else if (f3 == 3'd1) begin
        mis = off[0];
        we  = (off == 2'd2) ? 4'b1100 : 4'b0011;
        wo  = {wd[15:0], wd[15:0]};
      end else if (f3 == 3'd2) begin
        mis = (off != 2'd0);
        we  = 4'b1111;
      end else begin
        mis = 1'b1;
      end
    end else begin
      mis = (f3 == 3'd3) || (f3 >= 3'd6) ||
            (((f3 == 3'd1) || (f3 == 3'd5)) && off[0]) ||
            ((f3 == 3'd2) && (off != 2'd0));
    end
  endfunction

  // gw: REQ cycles without grant; rw: WAIT cycles until rvalid (0 = with grant).
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gw, input int rw,
                        input logic [31:0] rdata);
    logic        mis;
    logic [3:0]  we;
    logic [31:0] wo;
    exp_t        e;
    int          a;
    model(st, f3, addr[1:0], wdata, mis, we, wo);
    ex_valid = 1'b1; ex_is_store = st; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
    check("ex_ready_idle", ex_ready, 1);
    a = cyc + 1;
    e.is_load = !st; e.f3 = f3; e.off = addr[1:0];
    if (mis) begin
      e.kind = K_MIS; e.rdata = 32'h0; e.cyc = a;
    end else begin
      if (!st) wb_rdata_m = rdata;
      e.kind = K_WB; e.rdata = wb_rdata_m; e.cyc = a + gw + 1 + (st ? 0 : rw);
    end
    sb.push_back(e);
    step();
    ex_valid = 1'b0;
    if (mis) begin
      check("mis_no_req", d_req, 0);
      check("mis_ready", ex_ready, 1);
    end else begin
      check("req_addr", d_addr, {addr[31:2], 2'b00});
      check("req_we", d_we, we);
      if (st) check("req_wdata", d_wdata, wo);
      for (int i = 0; i < gw; i++) begin
        check("req_held", d_req, 1);
        check("busy_req", ex_ready, 0);
        d_rvalid = 1'b1;          // must be ignored without a grant
        d_rdata  = $urandom;
        step();
      end
      check("req_held", d_req, 1);
      check("req_addr_stable", d_addr, {addr[31:2], 2'b00});
      d_gnt = 1'b1; d_rvalid = (!st && rw == 0); d_rdata = rdata;
      step();
      d_gnt = 1'b0; d_rvalid = 1'b0;
      if (!st && rw > 0) begin
        for (int i = 1; i < rw; i++) begin
          check("wait_no_req", d_req, 0);
          check("busy_wait", ex_ready, 0);
          d_rdata = $urandom;
          step();
        end
        check("busy_wait", ex_ready, 0);
        d_rvalid = 1'b1; d_rdata = rdata;
        step();
        d_rvalid = 1'b0;
      end
    end
  endtask

  task automatic run_timeout(input bit in_wait);
    exp_t e;
    ex_valid = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h0000_5008; ex_wdata = 32'h0;
    check("ex_ready_idle", ex_ready, 1);
    e.kind = K_BERR; e.is_load = 1'b1; e.f3 = 3'b010; e.off = 2'd0; e.rdata = 32'h0;
    e.cyc = cyc + 1 + (in_wait ? 1 : 0) + TO;
    sb.push_back(e);
    step();
    ex_valid = 1'b0;
    if (in_wait) begin
      d_gnt = 1'b1;
      step();
      d_gnt = 1'b0;
    end
    for (int i = 0; i < TO; i++) begin
      check("to_busy", ex_ready, 0);
      step();
    end
    check("to_idle", ex_ready, 1);
    check("to_no_req", d_req, 0);
    d_gnt = 1'b1; d_rvalid = 1'b1; d_rdata = 32'hDEAD_BEEF;   // late response, must be ignored
    step();
    step();
    d_gnt = 1'b0; d_rvalid = 1'b0;
    check("to_late_idle", ex_ready, 1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || misalign || bus_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_evt", {29'h0, bus_err, misalign, wb_valid}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("evt_kind", {29'h0, bus_err, misalign, wb_valid}, {29'h0, e.kind});
        check("evt_cycle", cyc, e.cyc);
        if (e.kind == K_WB) begin
          check("wb_is_load", wb_is_load, e.is_load);
          check("wb_funct3", wb_funct3, e.f3);
          check("wb_offset", wb_offset, e.off);
          check("wb_rdata", wb_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_valid = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
    d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", ex_ready, 1);
    check("rst_req", d_req, 0);
    check("rst_we", d_we, 0);
    check("rst_addr", d_addr, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rdata", wb_rdata, 0);
    check("rst_misalign", misalign, 0);
    check("rst_bus_err", bus_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // SB at 0x1003, immediate grant.
    run_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
    // LH at 0x2002, grant after 3 cycles, rvalid 2 cycles later.
    run_op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 3, 2, 32'hBEEF_1234);
    // LW misaligned.
    run_op(1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 0, 32'h0);
    // LBU zero-latency memory, then LW accepted while wb_valid is high.
    run_op(1'b0, 3'b100, 32'h0000_0040, 32'h0, 0, 0, 32'h0000_0080);
    run_op(1'b0, 3'b010, 32'h0000_0044, 32'h0, 0, 1, 32'h1234_5678);
    // SH upper half, SW, unused funct3.
    run_op(1'b1, 3'b001, 32'h0000_7006, 32'hCAFE_8765, 1, 0, 32'h0);
    run_op(1'b1, 3'b010, 32'h0000_7008, 32'h0BAD_F00D, 2, 0, 32'h0);
    run_op(1'b0, 3'b011, 32'h0000_7000, 32'h0, 0, 0, 32'h0);

    for (int n = 0; n < 16; n++) begin
      logic st;
      logic [2:0] f3;
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      run_op(st, f3, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
    end

    run_timeout(1'b0);
    run_timeout(1'b1);

    // Reset while waiting for rvalid.
    run_op(1'b0, 3'b001, 32'h0000_ABC2, 32'h0, 0, 1, 32'h5A5A_A5A5);
    ex_valid = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h0000_6004;
    step();
    ex_valid = 1'b0; d_gnt = 1'b1;
    step();
    d_gnt = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", ex_ready, 1);
    check("arst_req", d_req, 0);
    check("arst_addr", d_addr, 0);
    check("arst_wb_rdata", wb_rdata, 0);
    check("arst_wb_is_load", wb_is_load, 0);
    check("arst_wb_funct3", wb_funct3, 0);
    check("arst_wb_offset", wb_offset, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    d_rvalid = 1'b1; d_gnt = 1'b1; d_rdata = 32'hFFFF_FFFF;
    step();
    step();
    d_rvalid = 1'b0; d_gnt = 1'b0;
    check("arst_stray_idle", ex_ready, 1);
    check("arst_stray_rdata", wb_rdata, 0);

    repeat (3) step();
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit of the 5-stage RISC-V core.
- Accepts one memory op at a time from EX and runs a req/gnt/rvalid handshake to data memory.
- Steers store bytes and generates byte enables.
- Registers the raw load word, funct3 and byte offset into the WB pipeline register, where the load sign/zero-extension logic consumes them.
- Stalls the pipeline while an access is outstanding and flags misalignment and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in REQ or WAIT before the access is abandoned with bus_err. Range 1..65535.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents a memory op
- ex_ready  out  1  LSU accepts the op this cycle
- ex_is_store  in  1  1 = store, 0 = load
- ex_funct3  in  3  RV32I load/store funct3
- ex_addr  in  32  effective byte address
- ex_wdata  in  32  store source (rs2)
- d_req  out  1  memory request valid
- d_gnt  in  1  memory accepted the request
- d_we  out  4  byte write enables (0000 for loads)
- d_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- d_wdata  out  32  lane-steered store data
- d_rvalid  in  1  load data valid
- d_rdata  in  32  load data word
- wb_valid  out  1  one-cycle retire pulse to WB
- wb_is_load  out  1  retired op was a load
- wb_funct3  out  3  funct3 of the retired op
- wb_offset  out  2  addr[1:0] of the retired op
- wb_rdata  out  32  raw memory word, unextended
- misalign  out  1  one-cycle pulse: misaligned op rejected
- bus_err  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - d_req=0, d_we=0, d_addr=0, d_wdata=0.
  - wb_valid=0, wb_is_load=0, wb_funct3=0, wb_offset=0, wb_rdata=0.
  - misalign=0, bus_err=0, timeout counter=0.
  - Reset mid-access aborts the access. A d_rvalid or d_gnt arriving later while in IDLE is ignored.
- ex_ready = (state==IDLE). An op is accepted when ex_valid && ex_ready.
- Misalignment, checked at accept:
  - LH/LHU/SH misaligned when addr[0]=1.
  - LW/SW misaligned when addr[1:0]!=0.
  - LB/LBU/SB are never misaligned.
  - Unused funct3 values (011, 110, 111) are treated as misaligned.
  - A misaligned op pulses misalign for 1 cycle the next cycle, issues no request, stays in IDLE and produces no wb_valid.
- Store steering, registered at accept:
  - SB: d_wdata={4{wdata[7:0]}}, d_we=4'b0001<<addr[1:0].
  - SH: d_wdata={2{wdata[15:0]}}, d_we = addr[1] ? 1100 : 0011.
  - SW: d_wdata=wdata, d_we=1111.
  - Loads: d_we=0000.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - An aligned op moves to REQ.
  - d_req=1 from the next cycle, with d_addr/d_we/d_wdata, funct3 and offset captured.
  - Counter cleared.
- REQ: d_req stays high with all request fields stable until d_gnt.
  - d_gnt on a store: next cycle wb_valid=1, wb_is_load=0, wb_rdata unchanged; go to IDLE.
  - d_gnt on a load without d_rvalid: go to WAIT; d_req drops.
  - d_gnt and d_rvalid in the same cycle (zero-latency memory): capture d_rdata; wb_valid=1 next cycle; go to IDLE.
- WAIT: on d_rvalid, wb_rdata<=d_rdata, wb_is_load=1, wb_valid=1 for one cycle; go to IDLE.
- d_rvalid is ignored in IDLE, and in REQ without d_gnt.
- Timeout:
  - The counter increments each cycle in REQ or WAIT and clears on every state change.
  - When it reaches TIMEOUT_CYCLES-1 without the completing event: bus_err pulses 1 cycle, d_req drops, no wb_valid, go to IDLE.
- Latency, accept to wb_valid: 2 cycles minimum (gnt+rvalid in the first REQ cycle), otherwise 2 + gnt wait + rvalid wait.
- Back-to-back ops: a new accept is possible in the cycle wb_valid is high.
- wb_funct3 and wb_offset update together with wb_valid and hold until the next retire.

Decomposition:
- Shared header (existing Opcode.vh): FNC_LB/LH/LW/LBU/LHU/SB/SH/SW funct3 constants.
- New LSU state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2) go in the same shared include.
- One combinational sub-module, store_align: funct3, offset, wdata -> d_we, d_wdata, misalign. It is reused by the verification model.

Test Plan:
- SB at addr 0x1003, rs2=0x000000A5, d_gnt in the first REQ cycle -> d_we=1000, d_wdata=0xA5A5A5A5, d_addr=0x1000; wb_valid 2 cycles after accept with wb_is_load=0.
- LH at 0x2002, gnt after 3 cycles, rvalid 2 cycles later with 0xBEEF1234 -> ex_ready low throughout; wb_rdata=0xBEEF1234, wb_offset=2, wb_funct3=001, wb_valid a single pulse.
- LW at 0x3001 -> misalign pulse 1 cycle, d_req never asserted, no wb_valid, ex_ready high the next cycle.
- LBU at 0x40, d_gnt and d_rvalid in the same cycle with 0x80 -> wb_valid 2 cycles after accept, wb_rdata=0x00000080; a second LW is accepted the cycle wb_valid is high.
- TIMEOUT_CYCLES=4, load granted, no rvalid -> bus_err pulse after 4 WAIT cycles, return to IDLE; a late d_rvalid is ignored and no wb_valid occurs.
- rst_n low in WAIT -> all outputs 0 asynchronously; after release, a stray d_rvalid=1 produces no wb_valid.
